// File: rtl/liteeth_sram_pkg.sv
// Shared sizing, types and pointer-wrap helper for the LiteEth SRAM FIFO.
package liteeth_sram_pkg;

   localparam int unsigned LITEETH_SRAM_BITS  = 32;
   localparam int unsigned LITEETH_SRAM_DEPTH = 384;
   localparam int unsigned LITEETH_SRAM_AW    = 9;

   typedef logic [LITEETH_SRAM_AW-1:0]   sram_addr_t;
   typedef logic [LITEETH_SRAM_BITS-1:0] sram_word_t;

   // The depth is not a power of two, so the last word wraps back to 0 explicitly.
   function automatic sram_addr_t ptr_inc(input sram_addr_t addr,
                                          input int unsigned depth = LITEETH_SRAM_DEPTH);
      return (addr == sram_addr_t'(depth - 1)) ? '0 : addr + sram_addr_t'(1);
   endfunction

endpackage

// File: rtl/liteeth_sram_fifo_obuf.sv
// Two-entry output buffer. It absorbs the one-cycle SRAM read latency, and entry 0 is always the head.
module liteeth_sram_fifo_obuf
   import liteeth_sram_pkg::*;
#(
   parameter int unsigned BITS = LITEETH_SRAM_BITS
)(
   input  logic            clk,
   input  logic            load_i,
   input  logic [BITS-1:0] data_i,
   input  logic            pop_i,
   input  logic            clear_i,
   output logic [1:0]      count_o,
   output logic [BITS-1:0] head_o
);

   logic [1:0]      cnt_q, cnt_d;
   logic [BITS-1:0] e0_q, e0_d, e1_q, e1_d;

   always_comb begin
      cnt_d = cnt_q;
      e0_d  = e0_q;
      e1_d  = e1_q;
      if (clear_i) begin
         cnt_d = '0;
      end else begin
         unique case ({load_i, pop_i})
            2'b10: begin
               if (cnt_q == 2'd0) e0_d = data_i;
               else               e1_d = data_i;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               e0_d  = e1_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd2) begin
                  e0_d = e1_q;
                  e1_d = data_i;
               end else begin
                  e0_d = data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   // Payload registers carry no reset; the count alone qualifies them.
   always_ff @(posedge clk) begin
      e0_q <= e0_d;
      e1_q <= e1_d;
   end

   assign count_o = cnt_q;
   assign head_o  = e0_q;

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// FIFO controller for a 1RW+1R SRAM macro, with valid/ready streams on both sides.
// Optional LITEETH_SRAM_FIFO_LEVEL_EN adds registered level and almost_full outputs.
module liteeth_sram_fifo_ctrl
   import liteeth_sram_pkg::*;
#(
   parameter int unsigned BITS        = LITEETH_SRAM_BITS,
   parameter int unsigned WORD_DEPTH  = LITEETH_SRAM_DEPTH,
   parameter int unsigned ADDR_WIDTH  = LITEETH_SRAM_AW,
   parameter int unsigned LEVEL_WIDTH = 10
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
   ,parameter int unsigned AFULL_THRESH = 368
`endif
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [BITS-1:0]       wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [BITS-1:0]       rd_data,
   output logic                  sram_rw0_ce,
   output logic                  sram_rw0_we,
   output logic [ADDR_WIDTH-1:0] sram_rw0_addr,
   output logic [BITS-1:0]       sram_rw0_wd,
   output logic                  sram_r0_ce,
   output logic [ADDR_WIDTH-1:0] sram_r0_addr,
   input  logic [BITS-1:0]       sram_r0_rd
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
   ,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic                   almost_full
`endif
);

   logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LEVEL_WIDTH-1:0] used_q, used_d, stored;
   logic                   inflight_q, inflight_d;
   logic [1:0]             ob_cnt;
   logic [2:0]             occ;
   logic                   clear, push, pop, issue, ret;

   assign clear    = ~rst_n | flush;
   assign wr_ready = (used_q < LEVEL_WIDTH'(WORD_DEPTH));
   assign rd_valid = (ob_cnt != 2'd0);
   assign push     = wr_valid & wr_ready & ~clear;
   assign pop      = rd_valid & rd_ready & ~clear;
   assign ret      = inflight_q & ~clear;

   // A word leaves used_q only when its read returns, so r0 never reads a slot rw0 may overwrite.
   assign stored = used_q - LEVEL_WIDTH'(inflight_q);
   assign occ    = 3'(ob_cnt) + 3'(inflight_q) - 3'(pop);
   assign issue  = ~clear & (stored != '0) & (occ < 3'd2);

   assign sram_rw0_ce   = push;
   assign sram_rw0_we   = push;
   assign sram_rw0_addr = wr_ptr_q;
   assign sram_rw0_wd   = wr_data;
   assign sram_r0_ce    = issue;
   assign sram_r0_addr  = rd_ptr_q;

   always_comb begin
      wr_ptr_d   = push  ? ptr_inc(wr_ptr_q, WORD_DEPTH) : wr_ptr_q;
      rd_ptr_d   = issue ? ptr_inc(rd_ptr_q, WORD_DEPTH) : rd_ptr_q;
      used_d     = used_q + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(ret);
      inflight_d = issue;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         used_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         used_q     <= used_d;
         inflight_q <= inflight_d;
      end
   end

   liteeth_sram_fifo_obuf #(.BITS(BITS)) u_obuf (
      .clk     (clk),
      .load_i  (ret),
      .data_i  (sram_r0_rd),
      .pop_i   (pop),
      .clear_i (clear),
      .count_o (ob_cnt),
      .head_o  (rd_data)
   );

`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
   logic [LEVEL_WIDTH-1:0] level_q, level_d;
   logic                   afull_q;

   assign level_d = used_q + LEVEL_WIDTH'(ob_cnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q <= '0;
         afull_q <= 1'b0;
      end else begin
         level_q <= level_d;
         afull_q <= (level_d >= LEVEL_WIDTH'(AFULL_THRESH));
      end
   end

   assign level       = level_q;
   assign almost_full = afull_q;
`endif

endmodule
